// File: rtl/que_slot_pkg.sv
// rtl/que_slot_pkg.sv - shared types and constants for the que slot push collector
package que_slot_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT   = 2'd1,
      S_COLLECT = 2'd2,
      S_CLOSE   = 2'd3
   } collector_state_e;

   localparam int QUE_SLOT_DATA_WIDTH = 9;
   localparam int QUE_SLOT_FIFO_WIDTH = 10;
   localparam int FIRST_BIT           = 8;
   localparam int LAST_BIT            = 9;

endpackage

// File: rtl/que_slot_sync_fifo.sv
// rtl/que_slot_sync_fifo.sv - single-clock first-word fall-through FIFO with free-entry count
module que_slot_sync_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 64
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     empty,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   free_entries
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_wr, do_rd;

   always_comb begin
      do_wr    = wr_en && !full;
      do_rd    = rd_en && !empty;
      wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q;
      if (do_wr && !do_rd) begin
         count_d = count_q + (AW+1)'(1);
      end else if (!do_wr && do_rd) begin
         count_d = count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset; the pointers define what is valid.
   always_ff @(posedge clock) begin
      if (do_wr) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   always_comb begin
      rd_data      = mem_q[rd_ptr_q];
      empty        = (count_q == '0);
      full         = (count_q == (AW+1)'(DEPTH));
      free_entries = (AW+1)'(DEPTH) - count_q;
   end

endmodule

// File: rtl/que_slot_push_collector.sv
// rtl/que_slot_push_collector.sv - grants a que slot handler, frames its push stream by idle
// timeout and buffers framed bytes for the switch egress
module que_slot_push_collector
   import que_slot_pkg::*;
#(
   parameter int FIFO_DEPTH = 64,
   parameter int IDLE_LIMIT = 12,
   parameter int HEADROOM   = 4
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic                           slot_ready,
   input  logic [QUE_SLOT_DATA_WIDTH-1:0] push_data,
   input  logic                           push_data_valid,
   input  logic                           push_data_ready,
   output logic                           enable,
   output logic                           push_data_enable,
   output logic [7:0]                     tx_data,
   output logic                           tx_first,
   output logic                           tx_last,
   output logic                           tx_valid,
   input  logic                           tx_ready,
   output logic [15:0]                    packet_count,
   output logic                           busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(IDLE_LIMIT + 1);

   collector_state_e state_q, state_d;

   logic                           hold_valid_q, hold_valid_d;
   logic [QUE_SLOT_DATA_WIDTH-1:0] hold_data_q, hold_data_d;
   logic [IW-1:0]                  idle_cnt_q, idle_cnt_d;
   logic [15:0]                    packet_count_q, packet_count_d;
   logic                           overflow_q, overflow_d;
   logic                           push_en_q, push_en_d;

   logic                           fifo_wr_req;
   logic                           fifo_wr_last;
   logic [QUE_SLOT_FIFO_WIDTH-1:0] fifo_wr_data;
   logic [QUE_SLOT_FIFO_WIDTH-1:0] fifo_rd_data;
   logic                           fifo_empty;
   logic                           fifo_full;
   logic [AW:0]                    fifo_free;
   logic                           room_ok;

   assign room_ok      = (fifo_free >= (AW+1)'(HEADROOM));
   assign fifo_wr_data = {fifo_wr_last, hold_data_q};

   que_slot_sync_fifo #(
      .WIDTH (QUE_SLOT_FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock        (clock),
      .reset_n      (reset_n),
      .wr_en        (fifo_wr_req),
      .wr_data      (fifo_wr_data),
      .rd_en        (tx_ready),
      .rd_data      (fifo_rd_data),
      .empty        (fifo_empty),
      .full         (fifo_full),
      .free_entries (fifo_free)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (slot_ready && room_ok) state_d = S_GRANT;
         S_GRANT:   if (push_data_ready) state_d = S_COLLECT;
         S_COLLECT: if (!push_data_valid && idle_cnt_q == IW'(IDLE_LIMIT - 1)) state_d = S_CLOSE;
         S_CLOSE:   state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_comb begin
      enable = (state_q == S_GRANT) || (state_q == S_COLLECT);
      busy   = (state_q != S_IDLE);
   end

   // Each new byte pushes the held one out; a flagged first byte on a full hold ends the packet.
   always_comb begin
      hold_valid_d   = hold_valid_q;
      hold_data_d    = hold_data_q;
      idle_cnt_d     = idle_cnt_q;
      packet_count_d = packet_count_q;
      overflow_d     = overflow_q;
      fifo_wr_req    = 1'b0;
      fifo_wr_last   = 1'b0;
      push_en_d      = room_ok;
      case (state_q)
         S_GRANT: begin
            if (push_data_ready) idle_cnt_d = '0;
         end
         S_COLLECT: begin
            if (push_data_valid) begin
               idle_cnt_d   = '0;
               hold_valid_d = 1'b1;
               hold_data_d  = push_data;
               if (hold_valid_q) begin
                  fifo_wr_req  = 1'b1;
                  fifo_wr_last = push_data[FIRST_BIT];
                  if (push_data[FIRST_BIT]) packet_count_d = packet_count_q + 16'd1;
               end
            end else begin
               idle_cnt_d = idle_cnt_q + IW'(1);
            end
         end
         S_CLOSE: begin
            idle_cnt_d   = '0;
            hold_valid_d = 1'b0;
            if (hold_valid_q) begin
               fifo_wr_req    = 1'b1;
               fifo_wr_last   = 1'b1;
               packet_count_d = packet_count_q + 16'd1;
            end
         end
         default: ;
      endcase
      if (fifo_wr_req && fifo_full) overflow_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         hold_valid_q   <= 1'b0;
         hold_data_q    <= '0;
         idle_cnt_q     <= '0;
         packet_count_q <= '0;
         overflow_q     <= 1'b0;
         push_en_q      <= 1'b0;
      end else begin
         hold_valid_q   <= hold_valid_d;
         hold_data_q    <= hold_data_d;
         idle_cnt_q     <= idle_cnt_d;
         packet_count_q <= packet_count_d;
         overflow_q     <= overflow_d;
         push_en_q      <= push_en_d;
      end
   end

   // Egress outputs read zero while the FIFO is empty.
   always_comb begin
      push_data_enable = push_en_q;
      packet_count     = packet_count_q;
      tx_valid         = !fifo_empty;
      tx_data          = fifo_empty ? 8'h00 : fifo_rd_data[7:0];
      tx_first         = !fifo_empty && fifo_rd_data[FIRST_BIT];
      tx_last          = !fifo_empty && fifo_rd_data[LAST_BIT];
   end

endmodule

// File: tb/tb_que_slot_push_collector.sv
// tb/tb_que_slot_push_collector.sv - self-checking bench for que_slot_push_collector
module tb_que_slot_push_collector;

   localparam int FIFO_DEPTH = 16;
   localparam int IDLE_LIMIT = 12;
   localparam int HEADROOM   = 4;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        slot_ready = 1'b0;
   logic [8:0]  push_data = '0;
   logic        push_data_valid = 1'b0;
   logic        push_data_ready = 1'b0;
   logic        tx_ready = 1'b1;
   logic        enable;
   logic        push_data_enable;
   logic [7:0]  tx_data;
   logic        tx_first;
   logic        tx_last;
   logic        tx_valid;
   logic [15:0] packet_count;
   logic        busy;

   int checks = 0;
   int failures = 0;

   typedef struct {
      int         grp;
      int         gap;
      logic [8:0] data;
      logic       exp_last;
   } push_vec_t;

   push_vec_t  vecs[$];
   logic [9:0] exp_q[$];

   always #5 clock = ~clock;

   que_slot_push_collector #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .IDLE_LIMIT (IDLE_LIMIT),
      .HEADROOM   (HEADROOM)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .slot_ready       (slot_ready),
      .push_data        (push_data),
      .push_data_valid  (push_data_valid),
      .push_data_ready  (push_data_ready),
      .enable           (enable),
      .push_data_enable (push_data_enable),
      .tx_data          (tx_data),
      .tx_first         (tx_first),
      .tx_last          (tx_last),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready),
      .packet_count     (packet_count),
      .busy             (busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: compare any egress pop at the falling edge, then return just after the rising edge.
   task automatic cyc();
      logic [9:0] e;
      @(negedge clock);
      if (tx_valid && tx_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL egress_unexpected: got %0h expected none", {tx_last, tx_first, tx_data});
         end else begin
            e = exp_q.pop_front();
            check("egress_entry", {22'b0, tx_last, tx_first, tx_data}, {22'b0, e});
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic start_grant();
      int n;
      n = 0;
      slot_ready      = 1'b1;
      push_data_ready = 1'b1;
      while (!enable && n < 50) begin
         cyc();
         n++;
      end
      check("grant_seen", {31'b0, enable}, 32'd1);
      slot_ready = 1'b0;
      cyc();
   endtask

   task automatic push_byte(input logic [8:0] d, input logic last);
      int n;
      n = 0;
      while (!push_data_enable && n < 100) begin
         cyc();
         n++;
      end
      push_data_valid = 1'b1;
      push_data       = d;
      exp_q.push_back({last, d});
      cyc();
      push_data_valid = 1'b0;
      push_data       = '0;
   endtask

   task automatic wait_idle(input string name);
      int k;
      k = 1;
      while (busy && k < 200) begin
         cyc();
         k++;
      end
      check(name, k, IDLE_LIMIT + 2);
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         cyc();
         n++;
      end
      repeat (3) cyc();
      check(name, exp_q.size(), 0);
   endtask

   task automatic run_group(input int g, input int exp_pc);
      start_grant();
      foreach (vecs[i]) begin
         if (vecs[i].grp == g) begin
            repeat (vecs[i].gap) cyc();
            push_byte(vecs[i].data, vecs[i].exp_last);
         end
      end
      wait_idle("close_latency");
      check("packet_count", packet_count, exp_pc);
      drain("drain");
   endtask

   initial begin
      int i;
      int low;
      int accepted_at_low;
      int guard;

      // grp 0: single packet, grp 1: gapped pushes, grp 2: protocol error split
      vecs.push_back('{0, 0, 9'h1A1, 1'b0});
      vecs.push_back('{0, 0, 9'h0B2, 1'b0});
      vecs.push_back('{0, 0, 9'h0C3, 1'b0});
      vecs.push_back('{0, 0, 9'h0D4, 1'b0});
      vecs.push_back('{0, 0, 9'h0E5, 1'b1});
      vecs.push_back('{1, 0, 9'h1C0, 1'b0});
      vecs.push_back('{1, 0, 9'h0C1, 1'b0});
      vecs.push_back('{1, 3, 9'h0C2, 1'b0});
      vecs.push_back('{1, 0, 9'h0C3, 1'b0});
      vecs.push_back('{1, IDLE_LIMIT - 1, 9'h0C4, 1'b1});
      vecs.push_back('{2, 0, 9'h1A0, 1'b0});
      vecs.push_back('{2, 0, 9'h0A1, 1'b0});
      vecs.push_back('{2, 0, 9'h0A2, 1'b1});
      vecs.push_back('{2, 0, 9'h1B0, 1'b0});
      vecs.push_back('{2, 0, 9'h0B1, 1'b1});

      #3;
      check("rst_enable", {31'b0, enable}, 0);
      check("rst_push_data_enable", {31'b0, push_data_enable}, 0);
      check("rst_tx_valid", {31'b0, tx_valid}, 0);
      check("rst_tx_bits", {22'b0, tx_last, tx_first, tx_data}, 0);
      check("rst_packet_count", packet_count, 0);
      check("rst_busy", {31'b0, busy}, 0);
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
      cyc();

      run_group(0, 1);
      run_group(1, 2);
      run_group(2, 4);

      // Empty grant: handler ready but never pushes.
      start_grant();
      wait_idle("empty_close_latency");
      check("empty_packet_count", packet_count, 4);
      drain("empty_drain");
      check("empty_tx_valid", {31'b0, tx_valid}, 0);

      // Backpressure: egress stalled until push_data_enable drops.
      tx_ready = 1'b0;
      start_grant();
      i = 0;
      low = 0;
      accepted_at_low = -1;
      guard = 0;
      while (i < 20 && guard < 300) begin
         if (push_data_enable) begin
            push_data_valid = 1'b1;
            push_data = (i == 0) ? 9'h140 : {1'b0, 8'(64 + i)};
            exp_q.push_back({(i == 19), push_data});
            i++;
         end else begin
            push_data_valid = 1'b0;
            if (accepted_at_low < 0) accepted_at_low = i;
            low++;
            if (low >= 3) tx_ready = 1'b1;
         end
         cyc();
         guard++;
      end
      push_data_valid = 1'b0;
      push_data = '0;
      check("bp_accepted_before_stall", accepted_at_low, 15);
      check("bp_all_pushed", i, 20);
      wait_idle("bp_close_latency");
      check("bp_packet_count", packet_count, 5);
      drain("bp_drain");

      // Asynchronous reset mid-packet.
      start_grant();
      push_byte(9'h1E0, 1'b0);
      push_byte(9'h0E1, 1'b0);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_enable", {31'b0, enable}, 0);
      check("mid_rst_tx_valid", {31'b0, tx_valid}, 0);
      check("mid_rst_packet_count", packet_count, 0);
      check("mid_rst_busy", {31'b0, busy}, 0);
      check("mid_rst_push_data_enable", {31'b0, push_data_enable}, 0);
      exp_q.delete();
      cyc();
      cyc();
      reset_n = 1'b1;
      cyc();
      run_group(0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/que_slot_push_collector.md
Name: que_slot_push_collector

Overview:
- Sits directly downstream of one que slot receive handler and consumes its 9-bit push stream (bit 8 = first-byte flag).
- Grants the slot, applies backpressure through push_data_enable, and closes packets itself: the push stream carries no last-byte marker, so end-of-packet is found by idle timeout.
- Buffers framed bytes in an internal FIFO and presents them to the switch egress side with first/last flags and a valid/ready handshake.

Parameters:
- FIFO_DEPTH, 64, entries in the internal FIFO (power of two, ≥16); entry = {last, first, byte[7:0]}.
- IDLE_LIMIT, 12, cycles without push_data_valid after the last accepted byte before the packet is closed. Must exceed the handler's own 8-cycle timeout.
- HEADROOM, 4, minimum free FIFO entries required to hold push_data_enable high.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- slot_ready  in  1  handler advertises a complete good packet.
- push_data  in  9  handler byte; [8] = first byte of packet.
- push_data_valid  in  1  push_data qualifier.
- push_data_ready  in  1  handler is in its push state.
- enable  out  1  grant to the handler.
- push_data_enable  out  1  backpressure; 1 = may push.
- tx_data  out  8  egress byte.
- tx_first  out  1  first byte of packet.
- tx_last  out  1  last byte of packet.
- tx_valid  out  1  egress qualifier.
- tx_ready  in  1  egress accept.
- packet_count  out  16  packets closed into the FIFO; wraps at 16'hFFFF→0.
- busy  out  1  state ≠ S_IDLE.

Behaviour:
- Reset: all outputs 0, FIFO empty, hold register empty, idle counter 0, state S_IDLE. Asynchronous assert, synchronous deassert behaviour at the flops.
- push_data_enable = registered (free_entries ≥ HEADROOM). It is computed in every state but is only meaningful while enable=1.
- Hold register: each accepted byte is staged in a one-entry hold register. When the next byte arrives, the held byte is written to the FIFO with last=0. When the packet closes, the held byte is written with last=1. A simultaneous FIFO write and read is allowed.
- FSM:
  - S_IDLE: enable=0. If slot_ready=1 and free_entries ≥ HEADROOM, go to S_GRANT.
  - S_GRANT: enable=1. When push_data_ready=1, clear the idle counter and go to S_COLLECT.
  - S_COLLECT: enable=1.
    - Each push_data_valid cycle: accept the byte, clear the idle counter, update the hold register.
    - No valid byte: idle counter +1. When it reaches IDLE_LIMIT, go to S_CLOSE.
  - S_CLOSE: enable=0. If the hold register is full, write it with last=1 and increment packet_count; otherwise write nothing (empty grant). Return to S_IDLE next cycle.
- First flag: FIFO entry first = push_data[8] as received.
- Protocol error: a byte with push_data[8]=1 while the hold register is full after ≥1 byte of the current packet. Flush the held byte with last=1, increment packet_count, and stage the new byte as the start of a new packet. Stay in S_COLLECT.
- Overflow guard: if the FIFO is full when a held byte must be written, drop that byte and set a sticky internal flag. The next closed entry is still written with last=1. This cannot occur when HEADROOM ≥ 2 is obeyed by the handler.
- Egress: tx_* are driven from the FIFO head. tx_valid = !empty. A pop occurs on tx_valid & tx_ready. First-word fall-through, zero-cycle read latency.
- Latency: a byte accepted at cycle N appears at the FIFO head no earlier than N+2 (hold stage + FIFO write). The last byte appears at IDLE_LIMIT+2 cycles after acceptance.
- Reset mid-packet: FIFO, hold register and count clear immediately. A partial packet is discarded.

Decomposition:
- Package que_slot_pkg:
  - collector state enum (S_IDLE, S_GRANT, S_COLLECT, S_CLOSE);
  - QUE_SLOT_DATA_WIDTH=9, QUE_SLOT_FIFO_WIDTH=10;
  - FIRST_BIT=8, LAST_BIT=9 index constants.
- Sub-module: que_slot_sync_fifo (parameterised width/depth, first-word fall-through, outputs empty, full, free_entries).

Test Plan:
- Single packet: slot_ready, then 5 bytes 0x1A1,0x0B2,0x0C3,0x0D4,0x0E5 back-to-back, tx_ready=1. Egress shows A1(first=1), B2, C3, D4, E5(last=1); packet_count=1; busy returns to 0 IDLE_LIMIT+2 cycles after the last push.
- Backpressure: FIFO_DEPTH=16, tx_ready=0, push 20 bytes. push_data_enable falls once free<4; no byte is lost after resuming tx_ready=1 (all 20 seen in order).
- Gapped pushes: gaps of 3 and IDLE_LIMIT-1 cycles within a packet. One packet only, last=1 only on the final byte.
- Protocol error: the second first-flagged byte arrives after 3 bytes. Two packets out (3 bytes and the remainder); packet_count=2.
- Empty grant: push_data_ready=1, no valid for IDLE_LIMIT cycles. Nothing is written, packet_count unchanged, state returns to S_IDLE.
- Async reset during S_COLLECT after 2 bytes. Outputs 0 immediately, tx_valid=0, packet_count=0, and the next packet is collected cleanly.
